regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_read_port.sv | 46 ++++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised multi-port register file.
// Build option REGFILE_BYPASS_EN enables write-to-read forwarding in regfile_mp.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 64;
    localparam int unsigned DEFAULT_NUM_REGS = 32;
    localparam int unsigned DEFAULT_NUM_RD   = 2;
    localparam int unsigned DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    // ZERO_REG value meaning "no hardwired-zero register"
    localparam int NO_ZERO_REG = -1;

    // Read-port index array for the default configuration
    typedef logic [DEFAULT_NUM_RD-1:0][DEFAULT_ADDR_W-1:0] rdIdx_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle of the register file: write, issue and read ports.
// The slave modport is the register file, the master is the pipeline.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD = DEFAULT_NUM_RD
);

    logic                           RegWrite;
    logic [ADDR_W-1:0]              WriteRegister;
    logic [DATA_W-1:0]              WriteData;
    logic [NUM_RD-1:0][ADDR_W-1:0]  ReadRegister;
    logic [NUM_RD-1:0][DATA_W-1:0]  ReadData;
    logic [NUM_RD-1:0]              ReadBusy;
    logic                           IssueValid;
    logic [ADDR_W-1:0]              IssueRegister;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister, IssueValid, IssueRegister,
        input  ReadData, ReadBusy
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister, IssueValid, IssueRegister,
        output ReadData, ReadBusy
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, hardwired-zero masking and,
// when REGFILE_BYPASS_EN is defined, same-cycle write forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int          ZERO_REG = int'(NUM_REGS) - 1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             busy,
    input  logic [ADDR_W-1:0]               readRegister,
`ifdef REGFILE_BYPASS_EN
    input  logic                            reset,
    input  logic                            regWrite,
    input  logic [ADDR_W-1:0]               writeRegister,
    input  logic [DATA_W-1:0]               writeData,
`endif
    output logic [DATA_W-1:0]               readData,
    output logic                            readBusy
);

    localparam bit                HAS_ZERO = (ZERO_REG != NO_ZERO_REG);
    localparam logic [ADDR_W-1:0] ZERO_IDX = HAS_ZERO ? ADDR_W'(ZERO_REG) : '0;

    logic isZero;
    assign isZero = HAS_ZERO && (readRegister == ZERO_IDX);

    always_comb begin
        readData = regs[readRegister];
        readBusy = busy[readRegister];
        if (isZero) begin
            readData = '0;
            readBusy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the writeback value unless reset is wiping the file this cycle
        else if (!reset && regWrite && (writeRegister == readRegister)) begin
            readData = writeData;
            readBusy = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD read ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_RD   = DEFAULT_NUM_RD,
    parameter int          ZERO_REG = int'(NUM_REGS) - 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave rf
);

    localparam int unsigned       ADDR_W   = $clog2(NUM_REGS);
    localparam bit                HAS_ZERO = (ZERO_REG != NO_ZERO_REG);
    localparam logic [ADDR_W-1:0] ZERO_IDX = HAS_ZERO ? ADDR_W'(ZERO_REG) : '0;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_RD-1:0][DATA_W-1:0]   rdData;
    logic [NUM_RD-1:0]               rdBusy;

    logic wrEn;
    logic issueEn;
    assign wrEn    = rf.RegWrite   && !(HAS_ZERO && (rf.WriteRegister == ZERO_IDX));
    assign issueEn = rf.IssueValid && !(HAS_ZERO && (rf.IssueRegister == ZERO_IDX));

    // Issue is applied after write so a new producer keeps its register busy
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wrEn) begin
                regs[rf.WriteRegister] <= rf.WriteData;
                busy[rf.WriteRegister] <= 1'b0;
            end
            if (issueEn) begin
                busy[rf.IssueRegister] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .regs         (regs),
            .busy         (busy),
            .readRegister (rf.ReadRegister[k]),
`ifdef REGFILE_BYPASS_EN
            .reset        (reset),
            .regWrite     (rf.RegWrite),
            .writeRegister(rf.WriteRegister),
            .writeData    (rf.WriteData),
`endif
            .readData     (rdData[k]),
            .readBusy     (rdBusy[k])
        );
    end

    assign rf.ReadData = rdData;
    assign rf.ReadBusy = rdBusy;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default, no-zero-register and 32x16x3 instances.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int unsigned  cyc;
        int           dut;
        int           port;
        logic [63:0]  data;
        logic         busy;
        logic [127:0] name;
    } exp_t;

    logic clk = 1'b0;
    logic rstA, rstB, rstC;
    int unsigned cyc = 0;
    int checks = 0;
    int fails  = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) ifA ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) ifB ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) ifC ();

    regfile_mp dutA (.clk(clk), .reset(rstA), .rf(ifA));
    regfile_mp #(.ZERO_REG(NO_ZERO_REG)) dutB (.clk(clk), .reset(rstB), .rf(ifB));
    regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) dutC (.clk(clk), .reset(rstC), .rf(ifC));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setA(input bit we, input logic [4:0] wa, input logic [63:0] wd,
                        input bit iv, input logic [4:0] ia,
                        input logic [4:0] r0, input logic [4:0] r1, input bit rst);
        rdIdx_t rr;
        rr[0] = r0;
        rr[1] = r1;
        ifA.RegWrite      = we;
        ifA.WriteRegister = wa;
        ifA.WriteData     = wd;
        ifA.IssueValid    = iv;
        ifA.IssueRegister = ia;
        ifA.ReadRegister  = rr;
        rstA              = rst;
    endtask

    task automatic expect_rd(input int dut, input int port, input logic [63:0] data,
                             input logic busy, input logic [127:0] name);
        q.push_back('{cyc, dut, port, data, busy, name});
    endtask

    function automatic logic [32:0] sweepVal(input int idx);
        // Bit 32 carries ReadBusy (always 0 in the sweep); r15 is the zero register
        return (idx == 15) ? 33'd0 : {1'b0, 32'(idx) * 32'h1111_1111};
    endfunction

    // Monitor: every negedge, consume the expectations due this cycle
    always @(negedge clk) begin
        logic [63:0] ad;
        logic        ab;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            ad = 'x;
            ab = 1'bx;
            case (e.dut)
                0: begin ad = ifA.ReadData[e.port]; ab = ifA.ReadBusy[e.port]; end
                1: begin ad = ifB.ReadData[e.port]; ab = ifB.ReadBusy[e.port]; end
                default: begin ad = {32'd0, ifC.ReadData[e.port]}; ab = ifC.ReadBusy[e.port]; end
            endcase
            if (e.cyc != cyc) begin
                checks++; fails++;
                $display("FAIL %0s stale: due cycle %0d, seen cycle %0d", e.name, e.cyc, cyc);
            end else begin
                checks++;
                if (ad !== e.data) begin
                    fails++;
                    $display("FAIL %0s data dut%0d p%0d: got %h want %h", e.name, e.dut, e.port, ad, e.data);
                end
                checks++;
                if (ab !== e.busy) begin
                    fails++;
                    $display("FAIL %0s busy dut%0d p%0d: got %b want %b", e.name, e.dut, e.port, ab, e.busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] sv;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        setA(0, 0, 0, 0, 0, 0, 1, 1);
        ifB.RegWrite = 0; ifB.WriteRegister = 0; ifB.WriteData = 0;
        ifB.IssueValid = 0; ifB.IssueRegister = 0; ifB.ReadRegister = '0;
        ifC.RegWrite = 0; ifC.WriteRegister = 0; ifC.WriteData = 0;
        ifC.IssueValid = 0; ifC.IssueRegister = 0; ifC.ReadRegister = '0;
        step(); step();
        rstB = 1'b0; rstC = 1'b0;

        // Reset state
        setA(0, 0, 0, 0, 0, 0, 1, 0);
        expect_rd(0, 0, 0, 0, "rst_r0"); expect_rd(0, 1, 0, 0, "rst_r1");

        // Reset clears data and busy
        step(); setA(1, 5, 64'hDEADBEEF_00000001, 1, 7, 5, 7, 0);
        step(); setA(0, 0, 0, 0, 0, 5, 7, 1);
        expect_rd(0, 0, 64'hDEADBEEF_00000001, 0, "pre_r5"); expect_rd(0, 1, 0, 1, "pre_r7");
        step(); setA(0, 0, 0, 0, 0, 5, 7, 0);
        expect_rd(0, 0, 0, 0, "clr_r5"); expect_rd(0, 1, 0, 0, "clr_r7");

        // Write then read on all ports
        step(); setA(1, 3, 64'h0123456789ABCDEF, 0, 0, 3, 3, 0);
        expect_rd(0, 0, BYP ? 64'h0123456789ABCDEF : 64'd0, 0, "wr_same_p0");
        expect_rd(0, 1, BYP ? 64'h0123456789ABCDEF : 64'd0, 0, "wr_same_p1");
        step(); setA(0, 0, 0, 0, 0, 3, 3, 0);
        expect_rd(0, 0, 64'h0123456789ABCDEF, 0, "wr_next_p0");
        expect_rd(0, 1, 64'h0123456789ABCDEF, 0, "wr_next_p1");

        // Zero register, and the same traffic on a file without one
        step(); setA(1, 31, '1, 1, 31, 31, 31, 0);
        ifB.RegWrite = 1; ifB.WriteRegister = 31; ifB.WriteData = '1;
        ifB.IssueValid = 1; ifB.IssueRegister = 31; ifB.ReadRegister = {5'd31, 5'd31};
        expect_rd(0, 0, 0, 0, "zr_same");
        expect_rd(1, 0, BYP ? '1 : 64'd0, 0, "nz_same");
        step(); setA(0, 0, 0, 0, 0, 31, 31, 0);
        ifB.RegWrite = 0; ifB.IssueValid = 0;
        expect_rd(0, 0, 0, 0, "zr_p0"); expect_rd(0, 1, 0, 0, "zr_p1");
        expect_rd(1, 0, '1, 1, "nz_r31"); expect_rd(1, 1, '1, 1, "nz_r31_p1");

        // Scoreboard
        step(); setA(0, 0, 0, 1, 10, 10, 10, 0); expect_rd(0, 0, 0, 0, "sb_iss_same");
        step(); setA(0, 0, 0, 1, 10, 10, 10, 0); expect_rd(0, 0, 0, 1, "sb_busy1");
        step(); setA(0, 0, 0, 0, 0, 10, 10, 0);  expect_rd(0, 0, 0, 1, "sb_busy2");
        step(); setA(1, 10, 64'h42, 0, 0, 10, 10, 0);
        expect_rd(0, 0, BYP ? 64'h42 : 64'd0, BYP ? 1'b0 : 1'b1, "sb_wr_same");
        step(); setA(0, 0, 0, 0, 0, 10, 10, 0);  expect_rd(0, 0, 64'h42, 0, "sb_wr_clr");
        step(); setA(1, 10, 64'h55, 1, 10, 10, 10, 0);
        expect_rd(0, 0, BYP ? 64'h55 : 64'h42, 0, "sb_both_same");
        step(); setA(0, 0, 0, 0, 0, 10, 10, 0);  expect_rd(0, 0, 64'h55, 1, "sb_both");

        // Reset dominates write/issue; forwarding is suppressed under reset
        step(); setA(1, 4, 64'h99, 1, 4, 4, 3, 1);
        expect_rd(0, 0, 0, 0, "rs_r4_same"); expect_rd(0, 1, 64'h0123456789ABCDEF, 0, "rs_r3_same");
        step(); setA(0, 0, 0, 0, 0, 4, 3, 0);
        expect_rd(0, 0, 0, 0, "rs_r4"); expect_rd(0, 1, 0, 0, "rs_r3");

        // Issue and write to different registers together
        step(); setA(1, 6, 64'h7, 1, 2, 2, 6, 0);
        expect_rd(0, 0, 0, 0, "sim_r2_same"); expect_rd(0, 1, BYP ? 64'h7 : 64'd0, 0, "sim_r6_same");
        step(); setA(0, 0, 0, 0, 0, 2, 6, 0);
        expect_rd(0, 0, 0, 1, "sim_r2"); expect_rd(0, 1, 64'h7, 0, "sim_r6");

        // 32-bit, 16-register, 3-port instance
        for (int i = 0; i < 16; i++) begin
            step();
            ifC.RegWrite = 1; ifC.WriteRegister = 4'(i); ifC.WriteData = 32'(i) * 32'h1111_1111;
        end
        for (int c = 0; c < 16; c++) begin
            step();
            ifC.RegWrite = 0;
            ifC.ReadRegister[0] = 4'(c);
            ifC.ReadRegister[1] = 4'((c + 5) % 16);
            ifC.ReadRegister[2] = 4'((c + 11) % 16);
            sv = sweepVal(c);             expect_rd(2, 0, {32'd0, sv[31:0]}, sv[32], "sweep_p0");
            sv = sweepVal((c + 5) % 16);  expect_rd(2, 1, {32'd0, sv[31:0]}, sv[32], "sweep_p1");
            sv = sweepVal((c + 11) % 16); expect_rd(2, 2, {32'd0, sv[31:0]}, sv[32], "sweep_p2");
        end

        step(); step();
        if (q.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
